// File: rtl/dbg_pkg.sv
// Shared types and defaults for the debug bus sequencer: request opcodes, FSM states and
// default control words.
package dbg_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_WRITE  = 2'b01,
    OP_OPCODE = 2'b10,
    OP_RSVD   = 2'b11
  } dbg_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSettle,
    StClkHi,
    StClkLo,
    StIclkHi,
    StIclkLo,
    StResp
  } dbg_state_e;

  localparam logic [31:0] CwMemReadDefault  = 32'h0000_0000;
  localparam logic [31:0] CwMemWriteDefault = 32'h0000_0000;
  localparam logic [31:0] CwIrFetchDefault  = 32'h0000_0000;

  // Wide enough for settle periods of 1..15 cycles.
  localparam int unsigned SettleWidth = 4;

endpackage

// File: rtl/dbg_bus_sequencer_if.sv
// Host request/response handshake plus CPU bus, control word and clock pulse signals of the
// debug bus sequencer. The sequencer uses the slave modport, the host side the master modport.
interface dbg_bus_sequencer_if;
  import dbg_pkg::*;

  logic        dbg_en;
  logic        ctrlen;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  bus_in;
  logic [7:0]  ir_in;
  logic [15:0] addr_out;
  logic        addr_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [31:0] cw_out;
  logic        clk_pulse;
  logic        iclk_pulse;

  modport slave (
    input  dbg_en, req_valid, req_op, req_addr, req_data, rsp_ready, bus_in, ir_in,
    output ctrlen, req_ready, rsp_valid, rsp_data, rsp_err, addr_out, addr_oe, data_out,
           data_oe, cw_out, clk_pulse, iclk_pulse
  );

  modport master (
    output dbg_en, req_valid, req_op, req_addr, req_data, rsp_ready, bus_in, ir_in,
    input  ctrlen, req_ready, rsp_valid, rsp_data, rsp_err, addr_out, addr_oe, data_out,
           data_oe, cw_out, clk_pulse, iclk_pulse
  );

endinterface

// File: rtl/dbg_settle_timer.sv
// Loadable down-counter; done is high on the last cycle of a loaded settle period.
module dbg_settle_timer
  import dbg_pkg::*;
#(
  parameter int unsigned Width = SettleWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == Width'(1));

endmodule

// File: rtl/dbg_bus_sequencer.sv
// Turns single debug requests (read, write, opcode fetch) into timed address/data/control-word
// drives and clk/iclk pulses. Optional write read-back check: define WRITE_VERIFY_EN.
module dbg_bus_sequencer
  import dbg_pkg::*;
#(
  parameter logic [31:0] CW_MEM_READ   = CwMemReadDefault,
  parameter logic [31:0] CW_MEM_WRITE  = CwMemWriteDefault,
  parameter logic [31:0] CW_IR_FETCH   = CwIrFetchDefault,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  dbg_bus_sequencer_if.slave bus
);

  localparam logic [SettleWidth-1:0] SettleLoad = SettleWidth'(SETTLE_CYCLES);

  dbg_state_e  state_q, state_d;
  dbg_op_e     op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        ctrlen_q, ctrlen_d;
  logic        req_ready, accept;
  logic        timer_load, timer_done;
`ifdef WRITE_VERIFY_EN
  logic        verify_q, verify_d;
`endif

  assign req_ready = ctrlen_q && (state_q == StIdle);
  assign accept    = bus.req_valid && req_ready;

  dbg_settle_timer #(
    .Width(SettleWidth)
  ) u_settle_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .load_value(SettleLoad),
    .done      (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StSetup;
      end
      StSetup: begin
        if (op_q == OP_RSVD) begin
          state_d = StResp;
        end else begin
          state_d    = StSettle;
          timer_load = 1'b1;
        end
      end
      StSettle: begin
        if (timer_done) begin
          if (op_q == OP_READ) begin
            state_d = StResp;
`ifdef WRITE_VERIFY_EN
          end else if (verify_q) begin
            state_d = StResp;
`endif
          end else begin
            state_d = StClkHi;
          end
        end
      end
      StClkHi: state_d = StClkLo;
      StClkLo: begin
        if (op_q == OP_OPCODE) begin
          state_d = StIclkHi;
        end else begin
`ifdef WRITE_VERIFY_EN
          // Second settle period reads the written location back.
          state_d    = StSettle;
          timer_load = 1'b1;
`else
          state_d = StResp;
`endif
        end
      end
      StIclkHi: state_d = StIclkLo;
      StIclkLo: state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control stays engaged until the FSM is heading back to idle, so a dropped dbg_en never
  // cuts a sequence short.
  assign ctrlen_d = bus.dbg_en || (state_d != StIdle);

  always_comb begin
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d       = dbg_op_e'(bus.req_op);
      addr_d     = bus.req_addr;
      data_d     = bus.req_data;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
    end else begin
      if (state_q == StSetup && op_q == OP_RSVD) begin
        rsp_err_d = 1'b1;
      end
      if (state_q == StSettle && timer_done && op_q == OP_READ) begin
        rsp_data_d = bus.bus_in;
      end
      if (state_q == StIclkLo) begin
        rsp_data_d = bus.ir_in;
      end
`ifdef WRITE_VERIFY_EN
      if (state_q == StSettle && timer_done && verify_q && bus.bus_in != data_q) begin
        rsp_err_d  = 1'b1;
        rsp_data_d = bus.bus_in;
      end
`endif
    end
  end

`ifdef WRITE_VERIFY_EN
  always_comb begin
    verify_d = verify_q;
    if (accept) begin
      verify_d = 1'b0;
    end else if (state_q == StClkLo && op_q == OP_WRITE) begin
      verify_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      verify_q <= 1'b0;
    end else begin
      verify_q <= verify_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      ctrlen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ctrlen_q   <= ctrlen_d;
    end
  end

  logic [15:0] addr_out;
  logic        addr_oe;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [31:0] cw_out;

  always_comb begin
    addr_out = '0;
    addr_oe  = 1'b0;
    data_out = '0;
    data_oe  = 1'b0;
    cw_out   = '0;
    if (ctrlen_q && state_q != StIdle && op_q != OP_RSVD) begin
      addr_out = addr_q;
      addr_oe  = 1'b1;
      unique case (op_q)
        OP_READ:   cw_out = CW_MEM_READ;
        OP_WRITE: begin
          cw_out   = CW_MEM_WRITE;
          data_out = data_q;
          data_oe  = 1'b1;
        end
        OP_OPCODE: cw_out = CW_IR_FETCH;
        default:   cw_out = '0;
      endcase
`ifdef WRITE_VERIFY_EN
      if (verify_q) begin
        cw_out   = CW_MEM_READ;
        data_out = '0;
        data_oe  = 1'b0;
      end
`endif
    end
  end

  assign bus.ctrlen     = ctrlen_q;
  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.addr_out   = addr_out;
  assign bus.addr_oe    = addr_oe;
  assign bus.data_out   = data_out;
  assign bus.data_oe    = data_oe;
  assign bus.cw_out     = cw_out;
  assign bus.clk_pulse  = (state_q == StClkHi);
  assign bus.iclk_pulse = (state_q == StIclkHi);

endmodule

// File: tb/tb_dbg_bus_sequencer.sv
// Self-checking bench for dbg_bus_sequencer: directed scenarios plus randomized requests
// checked against a transaction-level model of latency, response and drive behaviour.
module tb_dbg_bus_sequencer;
  import dbg_pkg::*;

  localparam logic [31:0] CwRd   = 32'h1111_00A1;
  localparam logic [31:0] CwWr   = 32'h2222_00B2;
  localparam logic [31:0] CwIr   = 32'h3333_00C3;
  localparam int          Settle = 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  dbg_bus_sequencer_if ifc ();

  dbg_bus_sequencer #(
    .CW_MEM_READ  (CwRd),
    .CW_MEM_WRITE (CwWr),
    .CW_IR_FETCH  (CwIr),
    .SETTLE_CYCLES(Settle)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full request/response transaction; expectations come from the op's documented timing.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] data,
                         input logic [7:0] bval, input logic [7:0] ival, input int stall,
                         input bit drop_en, input string name);
    int          k, lat_exp, clk_exp, iclk_exp, n_clk, n_iclk;
    logic [7:0]  d_exp;
    logic        e_exp, aoe_exp, doe_exp;
    logic [31:0] cw_exp;
    bit          drv_bad, hold_bad;
    aoe_exp = (op != 2'b11);
    doe_exp = 1'b0;
    cw_exp  = '0;
    d_exp   = '0;
    e_exp   = 1'b0;
    clk_exp = 0;
    iclk_exp = 0;
    case (op)
      2'b00: begin lat_exp = Settle + 2; d_exp = bval; cw_exp = CwRd; end
      2'b01: begin
        lat_exp = Settle + 4; clk_exp = 1; cw_exp = CwWr; doe_exp = 1'b1;
`ifdef WRITE_VERIFY_EN
        lat_exp = lat_exp + Settle; cw_exp = CwRd; doe_exp = 1'b0;
        if (bval != data) begin e_exp = 1'b1; d_exp = bval; end
`endif
      end
      2'b10: begin lat_exp = Settle + 6; clk_exp = 1; iclk_exp = 1; d_exp = ival; cw_exp = CwIr; end
      default: begin lat_exp = 2; e_exp = 1'b1; end
    endcase

    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_addr  = addr;
    ifc.req_data  = data;
    ifc.bus_in    = bval;
    ifc.ir_in     = ival;
    ifc.rsp_ready = 1'b0;
    k = 0;
    while (!ifc.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (ifc.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s accept: req_ready=%b want 1 within 20 cycles", name, ifc.req_ready);
      ifc.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    // Scramble request inputs so unregistered use would show up.
    ifc.req_valid = 1'b0;
    ifc.req_op    = op ^ 2'b01;
    ifc.req_addr  = ~addr;
    ifc.req_data  = ~data;
    k = 1; n_clk = 0; n_iclk = 0; drv_bad = 0;
    while (!ifc.rsp_valid && k < 64) begin
      if (drop_en && k == 2) ifc.dbg_en = 1'b0;
      if (ifc.clk_pulse && ifc.iclk_pulse) drv_bad = 1;
      if (ifc.clk_pulse) n_clk++;
      if (ifc.iclk_pulse) n_iclk++;
      if (ifc.addr_oe !== aoe_exp || (aoe_exp && ifc.addr_out !== addr)) drv_bad = 1;
      if (k == 1 && ifc.data_oe !== (op == 2'b01)) drv_bad = 1;
      if (ifc.clk_pulse && op == 2'b01 && (ifc.data_oe !== 1'b1 || ifc.data_out !== data))
        drv_bad = 1;
      if (ifc.ctrlen !== 1'b1) drv_bad = 1;
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== lat_exp || ifc.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (valid=%b) want %0d", name, k, ifc.rsp_valid, lat_exp);
    end
    n_cmp++;
    if (ifc.rsp_data !== d_exp || ifc.rsp_err !== e_exp) begin
      n_bad++;
      $display("FAIL %s response: data=%h err=%b want data=%h err=%b", name, ifc.rsp_data,
               ifc.rsp_err, d_exp, e_exp);
    end
    n_cmp++;
    if (n_clk !== clk_exp || n_iclk !== iclk_exp) begin
      n_bad++;
      $display("FAIL %s pulses: clk=%0d iclk=%0d want clk=%0d iclk=%0d", name, n_clk, n_iclk,
               clk_exp, iclk_exp);
    end
    n_cmp++;
    if (drv_bad) begin
      n_bad++;
      $display("FAIL %s drives: got bad drive/overlap/ctrlen during sequence, want clean", name);
    end
    n_cmp++;
    if (ifc.cw_out !== cw_exp || ifc.addr_oe !== aoe_exp || ifc.data_oe !== doe_exp) begin
      n_bad++;
      $display("FAIL %s resp drives: cw=%h aoe=%b doe=%b want cw=%h aoe=%b doe=%b", name,
               ifc.cw_out, ifc.addr_oe, ifc.data_oe, cw_exp, aoe_exp, doe_exp);
    end
    hold_bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_data !== d_exp || ifc.cw_out !== cw_exp ||
          ifc.addr_oe !== aoe_exp || ifc.ctrlen !== 1'b1)
        hold_bad = 1;
    end
    n_cmp++;
    if (hold_bad) begin
      n_bad++;
      $display("FAIL %s hold: response/drives changed under backpressure, want held", name);
    end
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    n_cmp++;
    if (ifc.rsp_valid !== 1'b0 || ifc.addr_oe !== 1'b0 || ifc.data_oe !== 1'b0 ||
        ifc.cw_out !== 32'h0) begin
      n_bad++;
      $display("FAIL %s release: valid=%b aoe=%b doe=%b cw=%h want all 0", name, ifc.rsp_valid,
               ifc.addr_oe, ifc.data_oe, ifc.cw_out);
    end
    n_cmp++;
    if (drop_en) begin
      if (ifc.ctrlen !== 1'b0 || ifc.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s ctrlen drop: ctrlen=%b ready=%b want 0 0", name, ifc.ctrlen,
                 ifc.req_ready);
      end
      ifc.dbg_en = 1'b1;
      @(negedge clk);
    end else if (ifc.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s idle ready: req_ready=%b want 1", name, ifc.req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ifc.ctrlen !== 1'b0 || ifc.req_ready !== 1'b0 || ifc.rsp_valid !== 1'b0 ||
        ifc.addr_oe !== 1'b0 || ifc.data_oe !== 1'b0 || ifc.cw_out !== 32'h0 ||
        ifc.clk_pulse !== 1'b0 || ifc.iclk_pulse !== 1'b0 || ifc.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset outputs: ctrlen=%b ready=%b valid=%b aoe=%b cw=%h want all 0",
               ifc.ctrlen, ifc.req_ready, ifc.rsp_valid, ifc.addr_oe, ifc.cw_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ifc.ctrlen !== 1'b0 || ifc.req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL no dbg_en: ctrlen=%b ready=%b want 0 0", ifc.ctrlen, ifc.req_ready);
    end
    ifc.dbg_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ifc.ctrlen !== 1'b1 || ifc.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ctrlen rise: ctrlen=%b ready=%b want 1 1", ifc.ctrlen, ifc.req_ready);
    end
  endtask

  task automatic test_directed();
    run_txn(2'b00, 16'h8010, 8'h00, 8'h5A, 8'h00, 0, 1'b0, "read");
    run_txn(2'b01, 16'h0003, 8'hC3, 8'hC2, 8'h00, 0, 1'b0, "write_mismatch");
    run_txn(2'b01, 16'h0004, 8'h77, 8'h77, 8'h00, 0, 1'b0, "write_match");
    run_txn(2'b10, 16'h1234, 8'h00, 8'h00, 8'h1F, 0, 1'b0, "opcode");
    run_txn(2'b11, 16'hBEEF, 8'hAA, 8'h55, 8'h66, 0, 1'b0, "reserved");
  endtask

  task automatic test_backpressure_dbg_drop();
    run_txn(2'b00, 16'h4242, 8'h00, 8'h3C, 8'h00, 5, 1'b1, "bp_drop_read");
    run_txn(2'b10, 16'h0F0F, 8'h00, 8'h00, 8'hE1, 5, 1'b1, "bp_drop_opcode");
  endtask

  task automatic test_reset_mid_sequence();
    int k;
    ifc.req_valid = 1'b1;
    ifc.req_op    = 2'b10;
    ifc.req_addr  = 16'h5555;
    ifc.ir_in     = 8'h99;
    k = 0;
    while (!ifc.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
    k = 1;
    while (!ifc.clk_pulse && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (ifc.clk_pulse !== 1'b1 || k !== Settle + 2) begin
      n_bad++;
      $display("FAIL midreset clk_hi: pulse=%b at %0d want 1 at %0d", ifc.clk_pulse, k, Settle + 2);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifc.clk_pulse !== 1'b0 || ifc.iclk_pulse !== 1'b0 || ifc.addr_oe !== 1'b0 ||
        ifc.data_oe !== 1'b0 || ifc.cw_out !== 32'h0 || ifc.ctrlen !== 1'b0 ||
        ifc.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset outputs: clk=%b aoe=%b cw=%h ctrlen=%b want all 0",
               ifc.clk_pulse, ifc.addr_oe, ifc.cw_out, ifc.ctrlen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ifc.req_ready !== 1'b0 || ifc.ctrlen !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset release: ready=%b ctrlen=%b want 0 0", ifc.req_ready, ifc.ctrlen);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.req_ready !== 1'b1 || ifc.ctrlen !== 1'b1 || ifc.addr_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset idle: ready=%b ctrlen=%b aoe=%b want 1 1 0", ifc.req_ready,
               ifc.ctrlen, ifc.addr_oe);
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data, bval, ival;
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = 16'($urandom);
      data = 8'($urandom);
      bval = ($urandom_range(0, 3) == 0) ? data : 8'($urandom);
      ival = 8'($urandom);
      run_txn(op, addr, data, bval, ival, int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    ifc.dbg_en    = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.req_op    = 2'b00;
    ifc.req_addr  = '0;
    ifc.req_data  = '0;
    ifc.rsp_ready = 1'b0;
    ifc.bus_in    = '0;
    ifc.ir_in     = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_backpressure_dbg_drop();
    test_reset_mid_sequence();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_bus_sequencer.md
Name: dbg_bus_sequencer

Overview:
Synthesizable sequencer that converts single host-side debug requests (memory read, memory write, opcode fetch) into timed bus, control-word and clock-pulse sequences on the CPU's main bus, address bus and control word. It sits between the serial debug front end and the CPU bus drivers. It owns the tri-state enables and the clk/iclk pulses while debug control is engaged.

Parameters:
CW_MEM_READ, 32'h0000_0000, control word that puts memory contents on main bus
CW_MEM_WRITE, 32'h0000_0000, control word that latches main bus into memory
CW_IR_FETCH, 32'h0000_0000, control word that loads IR from memory
SETTLE_CYCLES, 2, cycles bus/control word held before sample or pulse (legal 1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dbg_en  in  1  host requests debug control of the CPU
ctrlen  out  1  debug owns clk/iclk/control word
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle if valid
req_op  in  2  00 READ, 01 WRITE, 10 OPCODE, 11 reserved
req_addr  in  16  target address
req_data  in  8  write data
rsp_valid  out  1  response present
rsp_ready  in  1  host consumes response
rsp_data  out  8  read data / opcode
rsp_err  out  1  reserved op (or verify mismatch)
bus_in  in  8  sampled main bus value
ir_in  in  8  instruction register value
addr_out  out  16  address bus drive value
addr_oe  out  1  drive address bus
data_out  out  8  main bus drive value
data_oe  out  1  drive main bus
cw_out  out  32  control word while ctrlen
clk_pulse  out  1  CPU clk pulse
iclk_pulse  out  1  CPU iclk pulse

Behaviour:
- Reset (async, rst_n low): state IDLE, every output 0, counter 0; takes effect immediately even mid-sequence, and pulses drop at once.
- ctrlen: rises the cycle after dbg_en is sampled high. When dbg_en falls, it clears only once the FSM is in IDLE; an in-flight sequence always completes, including its response handshake.
- req_ready = ctrlen && state==IDLE. Inputs are registered on acceptance.
- States: IDLE, SETUP, SETTLE, CLK_HI, CLK_LO, ICLK_HI, ICLK_LO, RESP.
- SETUP (1 cycle): addr_out=addr, addr_oe=1.
  - READ: cw=CW_MEM_READ.
  - WRITE: cw=CW_MEM_WRITE, data_out=data, data_oe=1.
  - OPCODE: cw=CW_IR_FETCH.
  - Reserved op: go straight to RESP with rsp_err=1, rsp_data=0, no drives.
- SETTLE: held SETTLE_CYCLES cycles via a down-counter.
  - READ: bus_in sampled into rsp_data on the last SETTLE cycle, then RESP.
  - WRITE and OPCODE: continue to CLK_HI.
- CLK_HI: clk_pulse=1 for one cycle. CLK_LO: one cycle low.
  - WRITE: then RESP.
  - OPCODE: then ICLK_HI (iclk_pulse=1, one cycle), then ICLK_LO; ir_in sampled in ICLK_LO, then RESP.
- clk_pulse and iclk_pulse are never high in the same cycle.
- RESP: rsp_valid=1 with drives and cw held until rsp_ready. On the handshake cycle, addr_oe, data_oe and cw clear and state returns to IDLE; a new request is accepted on the next cycle at the earliest.
- Latency from accept cycle N, SETTLE_CYCLES=2: READ rsp_valid at N+4, WRITE at N+6, OPCODE at N+8.
- addr_oe and data_oe are never asserted while ctrlen=0.

Optional Feature:
WRITE_VERIFY_EN
- Defined: after a WRITE's CLK_LO, cw switches to CW_MEM_READ and data_oe clears. The FSM then runs one SETTLE period and compares bus_in with req_data.
  - Mismatch: rsp_err=1, and rsp_data returns the read-back value.
  - WRITE latency becomes N+6+SETTLE_CYCLES.
- Undefined: WRITE always returns rsp_err=0 and rsp_data=0.

Decomposition:
- Package dbg_pkg holds: op encoding enum (OP_READ/OP_WRITE/OP_OPCODE/OP_RSVD), state enum, and default control-word constants.
- One natural sub-module: dbg_settle_timer, a loadable down-counter with a done flag, used for SETTLE and verify settle.

Test Plan:
- Reset mid-sequence: assert rst_n=0 during CLK_HI -> same cycle clk_pulse=0, all oe=0; after release, state IDLE and req_ready=0 until ctrlen.
- READ addr 16'h8010 with bus_in=8'h5A -> addr_out=8010, cw=CW_MEM_READ; rsp_valid at N+4, rsp_data=5A, rsp_err=0; no clk/iclk pulse.
- WRITE addr 16'h0003 data 8'hC3 -> data_oe=1 with data_out=C3 before the single clk_pulse; rsp_valid at N+6.
  - With WRITE_VERIFY_EN and bus_in=8'hC2: rsp_err=1, rsp_data=C2.
- OPCODE with ir_in=8'h1F -> exactly one clk_pulse then one iclk_pulse, non-overlapping; rsp_data=1F at N+8.
- Backpressure and dbg_en drop: hold rsp_ready=0 for 5 cycles and drop dbg_en during SETTLE -> sequence completes, rsp_valid and drives hold; ctrlen falls one cycle after the handshake.
- Reserved op 2'b11 -> rsp_valid at N+2, rsp_err=1, no oe or pulse asserted.
